// File: rtl/bk_arith_pkg.sv
// Shared arithmetic definitions for the Brent-Kung adder/subtractor harnesses:
// default operand width, segment-width helper and the result bundle type.
package bk_arith_pkg;

  // Default full operand width for the harnesses.
  localparam int BK_WIDTH = 64;

  // Each pipeline stage handles one half of the operand.
  function automatic int seg_width(input int width);
    return width / 2;
  endfunction

  // Result bundle produced by the harnesses at the default width.
  typedef struct packed {
    logic [BK_WIDTH-1:0] diff;
    logic                bout;
    logic                ovf;
  } bk_result_t;

endpackage

// File: rtl/bk_seg_sub.sv
// Combinational N-bit subtract segment: d = x + ~y + ~bin, bout = ~carry_out.
// Carries come from a Brent-Kung parallel-prefix tree (up-sweep then
// down-sweep). The incoming carry is folded into bit 0's generate so every
// final prefix node is directly the carry into the next bit.
module bk_seg_sub #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout
);

  localparam int L      = (N > 1) ? $clog2(N) : 1;
  localparam int STAGES = 2 * L - 1;

  logic         cin;
  logic [N-1:0] p;
  logic [N-1:0] g;
  logic [N-1:0] gs [0:STAGES];
  logic [N-1:0] ps [0:STAGES];

  // Subtraction as addition of the one's complement with inverted borrow.
  assign cin = ~bin;
  assign p   = x ^ ~y;
  assign g   = x & ~y;

  assign gs[0] = {g[N-1:1], g[0] | (p[0] & cin)};
  assign ps[0] = p;

  // Stages 1..L are the up-sweep (levels 0..L-1), stages L+1..2L-1 the
  // down-sweep (levels L-2..0). Nodes that do not combine pass through.
  for (genvar gk = 1; gk <= STAGES; gk++) begin : g_stage
    localparam bit UP = (gk <= L);
    localparam int LV = UP ? (gk - 1) : (2 * L - 1 - gk);
    localparam int SP = 1 << LV;
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      localparam bit COMB = UP ? (((gi + 1) % (2 * SP)) == 0)
                               : ((((gi + 1) % (2 * SP)) == SP) && (gi >= 3 * SP - 1));
      if (COMB) begin : g_comb
        assign gs[gk][gi] = gs[gk-1][gi] | (ps[gk-1][gi] & gs[gk-1][gi-SP]);
        assign ps[gk][gi] = ps[gk-1][gi] & ps[gk-1][gi-SP];
      end else begin : g_pass
        assign gs[gk][gi] = gs[gk-1][gi];
        assign ps[gk][gi] = ps[gk-1][gi];
      end
    end
  end

  // Final prefix node i is the carry into bit i+1.
  assign d    = p ^ {gs[STAGES][N-2:0], cin};
  assign bout = ~gs[STAGES][N-1];

endmodule

// File: rtl/bk_pipelined_subtractor.sv
// Two-stage pipelined WIDTH-bit subtractor: diff = a - b - bin.
// Stage 1 subtracts the low segment and registers its borrow together with
// the high operand halves; stage 2 subtracts the high segment and registers
// the full result. valid/ready handshake on both sides allows stalling.
// Optional feature macro BK_SUB_OVF_EN: when defined, ovf reports signed
// overflow; otherwise ovf is tied low and carries no flop.
module bk_pipelined_subtractor
  import bk_arith_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH  // must be even
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int SEG = seg_width(WIDTH);

  // Handshake state
  logic s1_valid_reg;
  logic out_valid_reg;
  logic s2_free;
  logic accept;
  logic advance;

  // Stage 1 datapath
  logic [SEG-1:0] lo_diff;
  logic           lo_borrow;
  logic [SEG-1:0] lo_diff_reg;
  logic           lo_borrow_reg;
  logic [SEG-1:0] a_hi_reg;
  logic [SEG-1:0] b_hi_reg;

  // Stage 2 datapath
  logic [SEG-1:0]   hi_diff;
  logic             hi_borrow;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;

  // Output slot frees when empty or being consumed; stage 1 can take a new
  // beat whenever it is empty or about to move forward.
  assign s2_free  = !out_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || s2_free;
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid_reg && s2_free;

  // Low-segment subtract on the incoming operands.
  bk_seg_sub #(.N(SEG)) u_seg_lo (
    .x   (a[SEG-1:0]),
    .y   (b[SEG-1:0]),
    .bin (bin),
    .d   (lo_diff),
    .bout(lo_borrow)
  );

  // High-segment subtract on the registered operands and registered borrow.
  bk_seg_sub #(.N(SEG)) u_seg_hi (
    .x   (a_hi_reg),
    .y   (b_hi_reg),
    .bin (lo_borrow_reg),
    .d   (hi_diff),
    .bout(hi_borrow)
  );

  // Stage 1 occupancy: set on accept, cleared when it advances without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
    end else if (advance) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Stage 1 datapath capture; contents only matter while s1_valid_reg is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      lo_diff_reg   <= lo_diff;
      lo_borrow_reg <= lo_borrow;
      a_hi_reg      <= a[WIDTH-1:SEG];
      b_hi_reg      <= b[WIDTH-1:SEG];
    end
  end

  // Output valid: set on advance, cleared when consumed with nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
    end else if (advance) begin
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Output result register; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_reg <= '0;
      bout_reg <= 1'b0;
    end else if (advance) begin
      diff_reg <= {hi_diff, lo_diff_reg};
      bout_reg <= hi_borrow;
    end
  end

`ifdef BK_SUB_OVF_EN
  logic ovf_reg;

  // Signed overflow: operand signs differ and the result sign differs from a.
  // a's sign bit rides along in a_hi_reg, so no extra stage-1 flop is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (advance) begin
      ovf_reg <= (a_hi_reg[SEG-1] ^ b_hi_reg[SEG-1]) & (hi_diff[SEG-1] ^ a_hi_reg[SEG-1]);
    end
  end

  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid = out_valid_reg;
  assign diff      = diff_reg;
  assign bout      = bout_reg;

endmodule

// File: tb/tb_bk_pipelined_subtractor.sv
// Self-checking bench for bk_pipelined_subtractor: directed vectors with
// latency checks, backpressure, randomized stress against an arithmetic
// reference model with a scoreboard queue, and mid-operation reset.
module tb_bk_pipelined_subtractor;

  localparam int W = 64;
`ifdef BK_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  always #5 clk = ~clk;

  bk_pipelined_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf)
  );

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_deliv = 0;
  bit   acc = 1'b0;

  // Reference: wide unsigned subtraction; the extra top bit is the borrow.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t e;
    logic [W:0] t;
    t = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    e.diff = t[W-1:0];
    e.bout = t[W];
    e.ovf  = OVF_EN & (x[W-1] ^ y[W-1]) & (e.diff[W-1] ^ x[W-1]);
    return e;
  endfunction

  function automatic logic [W-1:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock of handshake bookkeeping, sampled at the falling edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      n_deliv++;
      if (exp_q.size() == 0) begin
        chk("spurious_out", W'(out_valid), '0);
      end else begin
        e = exp_q.pop_front();
        $display("tx out: diff=%h bout=%0b ovf=%0b", diff, bout, ovf);
        chk("sb_diff", diff, e.diff);
        chk("sb_bout", W'(bout), W'(e.bout));
        chk("sb_ovf", W'(ovf), W'(e.ovf));
      end
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model(a, b, bin));
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] da [5];
  logic [W-1:0] db [5];
  logic [W-1:0] dd [5];
  logic         dbin [5];
  logic         dbo [5];
  logic         dov [5];
  int           sent;
  int           cyc;

  initial begin
    da   = '{64'd5, 64'd0, 64'h0000_0001_0000_0000, 64'h8000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0};
    db   = '{64'd3, 64'd1, 64'd1, 64'd1, 64'h1234_5678_9ABC_DEF0};
    dbin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    dd   = '{64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
             64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    dbo  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    dov  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_diff", diff, '0);
    chk("rst_bout", W'(bout), '0);
    chk("rst_ovf", W'(ovf), '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1));

    // Directed vectors with exact two-cycle latency
    for (int i = 0; i < 5; i++) begin
      a = da[i]; b = db[i]; bin = dbin[i]; in_valid = 1'b1; out_ready = 1'b1;
      chk("dir_in_ready", W'(in_ready), W'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("dir_lat1", W'(out_valid), '0);
      @(posedge clk);
      #1;
      $display("tx dir%0d: a=%h b=%h bin=%0b -> diff=%h bout=%0b ovf=%0b", i, da[i], db[i], dbin[i], diff, bout, ovf);
      chk("dir_lat2", W'(out_valid), W'(1));
      chk("dir_diff", diff, dd[i]);
      chk("dir_bout", W'(bout), W'(dbo[i]));
      chk("dir_ovf", W'(ovf), W'(OVF_EN & dov[i]));
      @(posedge clk);
      #1;
      chk("dir_drain", W'(out_valid), '0);
    end

    // Backpressure: three beats, consumer stalled, then released
    out_ready = 1'b0; n_deliv = 0;
    a = r64(); b = r64(); bin = 1'b0; in_valid = 1'b1;
    cycle();
    chk("bp_acc0", W'(acc), W'(1));
    a = r64(); b = r64(); bin = 1'b1;
    cycle();
    chk("bp_acc1", W'(acc), W'(1));
    a = r64(); b = r64(); bin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("bp_in_ready", W'(in_ready), '0);
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk("bp_hold_diff", diff, exp_q[0].diff);
      cycle();
      chk("bp_no_acc", W'(acc), '0);
    end
    out_ready = 1'b1;
    cyc = 0;
    while (n_deliv < 3 && cyc < 20) begin
      cycle();
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    chk("bp_delivered", W'(n_deliv), W'(3));
    chk("bp_queue_empty", W'(exp_q.size()), '0);

    // Randomized stress with random valid/ready
    sent = 0; cyc = 0; acc = 1'b0; in_valid = 1'b0;
    while (sent < 1000 && cyc < 30000) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = r64(); bin = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: b = r64();
          1: b = a;
          2: begin a = W'($urandom_range(0, 7)); b = W'($urandom_range(0, 7)); end
          default: b = {a[W-1:W/2], 32'($urandom())};
        endcase
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (acc) sent++;
      cyc++;
    end
    chk("rnd_all_sent", W'(sent), W'(1000));
    in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      cycle();
      cyc++;
    end
    chk("rnd_drained", W'(exp_q.size()), '0);

    // Reset while both stages are full
    out_ready = 1'b0;
    a = r64(); b = r64(); bin = 1'b0; in_valid = 1'b1;
    cycle();
    a = r64(); b = r64();
    cycle();
    in_valid = 1'b0;
    chk("rst_mid_full", W'(out_valid), W'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", W'(out_valid), '0);
    chk("rst_mid_diff", diff, '0);
    chk("rst_mid_bout", W'(bout), '0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rst_no_stale", W'(out_valid), '0);
      cycle();
    end

    // Pipeline works again after reset
    n_deliv = 0;
    a = r64(); b = r64(); bin = 1'b1; in_valid = 1'b1;
    cyc = 0;
    while (n_deliv < 1 && cyc < 10) begin
      cycle();
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    chk("post_rst_deliver", W'(n_deliv), W'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bk_pipelined_subtractor.md
Name: bk_pipelined_subtractor

Overview:
- Two-stage pipelined 64-bit subtractor computing a - b - bin. It is the inverse operation of the team's pipelined Brent-Kung adder harness.
- Operands are split into two 32-bit segments. The borrow from the low segment is registered and passed to the high segment.
- valid/ready handshake on both sides, so it drops into datapath pipelines that stall, not only free-running timing harnesses.

Parameters:
- WIDTH, 64, total operand width; must be even.
- SEG, WIDTH/2, segment width per stage (derived; not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned)
- ovf  output  1  signed overflow (only with feature; see below)

Behaviour:
- Reset: one clock, rst_n asynchronous assert, synchronous deassert (the block registers have async clear only). While rst_n=0:
  - s1_valid=0, out_valid=0, diff=0, bout=0, ovf=0.
  - in_ready=1 once rst_n=1.
- Arithmetic: diff = a + ~b + ~bin, using per-segment Brent-Kung prefix carry. Borrow = NOT carry-out.
- Stage 1, on accept (in_valid & in_ready):
  - Register low diff[SEG-1:0] and low-segment borrow.
  - Register a[WIDTH-1:SEG], b[WIDTH-1:SEG].
  - Set s1_valid=1.
- Stage 2, on advance:
  - Compute high segment from registered high operands and registered borrow.
  - Register full diff, bout and ovf. Set out_valid=1.
- Latency: exactly 2 cycles from accept to out_valid with out_ready held high. Throughput: 1 op/cycle.
- Flow control:
  - s2_free = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_free (combinational, no dependency on in_valid).
  - Stage 1 advances into stage 2 when s1_valid & s2_free.
  - s1_valid clears if it advanced and no new accept occurs the same cycle.
- Stall: out_valid & !out_ready holds diff/bout/ovf stable. Stage 1 holds if occupied; in_ready falls once both stages are full. No beat is dropped or duplicated.
- Simultaneous events:
  - Accept and advance in the same cycle are legal; stage 1 reloads.
  - Output consume and advance in the same cycle keep out_valid=1 with the new data.
- Wrap-around: 0 - 1 gives all ones with bout=1. a == b with bin=1 gives all ones with bout=1.
- Reset mid-operation flushes both stages. In-flight results are lost and must not appear after reset release.
- Registers hold value when not loading. Datapath registers have no reset requirement beyond output registers, which reset to 0.

Optional Feature:
- Macro: BK_SUB_OVF_EN.
- Defined:
  - ovf = (a[W-1] ^ b[W-1]) & (diff[W-1] ^ a[W-1]).
  - a[W-1] is piped through stage 1; the flag is registered with diff.
- Undefined: ovf is tied to 0 and no extra flops exist. The port stays present so instantiations are unchanged.

Decomposition:
- Shared package (bk_arith_pkg):
  - BK_WIDTH=64 default constant.
  - Segment-width function.
  - Operand/result packed typedef {diff, bout, ovf}, reused by adder and subtractor harnesses.
- One sub-module: bk_seg_sub. Combinational SEG-wide Brent-Kung subtract segment with inputs (x, y, bin) and outputs (d, bout). Instantiated twice, once per stage.
- Handshake logic stays in the top module.

Test Plan:
- a=5, b=3, bin=0 -> diff=2, bout=0, out_valid exactly 2 cycles after accept.
- a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1. With BK_SUB_OVF_EN, ovf=0.
- a=0x0000_0001_0000_0000, b=1, bin=0 -> diff=0x0000_0000_FFFF_FFFF, bout=0 (borrow crosses segment boundary).
- With BK_SUB_OVF_EN, a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0.
- Backpressure: send 3 beats back-to-back with out_ready=0 for 5 cycles, then raise it.
  - Expect 2 results held, in_ready=0 while full, third beat accepted after release.
  - All 3 results delivered in order, none dropped.
- Stress and reset:
  - 1000 random beats with random in_valid/out_ready, compared against a scoreboard model (a-b-bin).
  - Assert rst_n low while both stages are full: out_valid=0 immediately (async), no stale output after release.
